// File: rtl/dma_2d_ci.sv
// Custom-instruction DMA: CPU-visible scratch memory plus a strided 2D bus master
// that moves lines of words between the wired-OR system bus and local memory.
module dma_2d_ci #(
  parameter logic [7:0] customId      = 8'hFE,
  parameter int         MEM_ADDR_BITS = 9,
  parameter int         MAX_BURST     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic        dmaRequestBusOut,
  input  logic        dmaAckBusIn,
  output logic        dmaBeginTransactionOut,
  output logic [31:0] dmaAddressDataOut,
  input  logic [31:0] dmaAddressDataIn,
  output logic [7:0]  dmaBurstSizeOut,
  output logic [3:0]  dmaByteEnablesOut,
  output logic        dmaDataValidOut,
  input  logic        dmaDataValidIn,
  output logic        dmaEndTransactionOut,
  input  logic        dmaEndTransactionIn,
  input  logic        dmaBusErrorIn,
  input  logic        dmaBusyIn
);
  localparam int AW = MEM_ADDR_BITS;
  localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_BEGIN = 3'd2, S_RD_DATA = 3'd3,
                         S_WR_DATA = 3'd4, S_WR_END = 3'd5, S_NEXT = 3'd6, S_ERROR = 3'd7;
  localparam logic [7:0]    BURST_MAX = 8'(MAX_BURST - 1);
  localparam logic [AW-1:0] PTR_ONE   = 1;

  logic [31:0]   r_mem [0:(1<<AW)-1];
  logic [2:0]    r_state;
  logic [31:0]   r_busStart, r_stride, r_lineBase, r_regRd, r_cpuRd, r_engRd;
  logic [AW-1:0] r_memStart, r_memPtr;
  logic [15:0]   r_lineLen, r_lineCount, r_wordsLeft, r_linesLeft, r_burstLeft;
  logic [7:0]    r_burst;
  logic          r_dirWr, r_busy, r_err, r_done, r_rdMem;

  logic          w_acc, w_we, w_cfgWr, w_go, w_err, w_engWr, w_wrXfer;
  logic [2:0]    w_sel;
  logic [AW-1:0] w_cpuAddr, w_engRdAddr;
  logic [15:0]   w_bp1, w_burstWords, w_burstM1, w_off;
  logic [31:0]   w_rdVal;
  logic          w_unused;

  assign w_acc     = start && (ciN == customId);
  assign w_we      = valueA[AW];
  assign w_sel     = valueA[AW+3:AW+1];
  assign w_cpuAddr = valueA[AW-1:0];
  assign w_cfgWr   = w_acc && w_we && (w_sel != 3'd0) && !r_busy;
  assign w_go      = w_cfgWr && (w_sel == 3'd7) && (valueB[1] ^ valueB[0]);
  assign w_err     = dmaBusErrorIn;
  assign w_engWr   = !reset && (r_state == S_RD_DATA) && dmaDataValidIn && !w_err;
  assign w_wrXfer  = (r_state == S_WR_DATA) && !dmaBusyIn;
  // Prefetch the next word on a transfer so back-to-back writes have no bubbles.
  assign w_engRdAddr  = w_wrXfer ? r_memPtr + PTR_ONE : r_memPtr;
  assign w_bp1        = {8'd0, r_burst} + 16'd1;
  assign w_burstWords = (r_wordsLeft < w_bp1) ? r_wordsLeft : w_bp1;
  assign w_burstM1    = w_burstWords - 16'd1;
  assign w_off        = r_lineLen - r_wordsLeft;
  assign w_unused     = ^{valueA[31:AW+4], w_burstM1[15:8]};

  always_comb begin
    w_rdVal = '0;
    case (w_sel)
      3'd1:    w_rdVal = r_busStart;
      3'd2:    w_rdVal = 32'(r_memStart);
      3'd3:    w_rdVal = {16'd0, r_lineLen};
      3'd4:    w_rdVal = {24'd0, r_burst};
      3'd5:    w_rdVal = {16'd0, r_lineCount};
      3'd6:    w_rdVal = r_stride;
      3'd7:    w_rdVal = {r_linesLeft, 14'd0, r_err, r_busy};
      default: w_rdVal = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_engWr) r_mem[r_memPtr] <= dmaAddressDataIn;
    else if (w_acc && w_we && (w_sel == 3'd0)) r_mem[w_cpuAddr] <= valueB;
    r_cpuRd <= r_mem[w_cpuAddr];
    r_engRd <= r_mem[w_engRdAddr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;     r_done <= 1'b0;      r_rdMem <= 1'b0;     r_regRd <= '0;
      r_busStart <= '0;      r_memStart <= '0;    r_lineLen <= '0;     r_burst <= '0;
      r_lineCount <= '0;     r_stride <= '0;      r_lineBase <= '0;    r_memPtr <= '0;
      r_wordsLeft <= '0;     r_linesLeft <= '0;   r_burstLeft <= '0;   r_dirWr <= 1'b0;
      r_busy <= 1'b0;        r_err <= 1'b0;
    end else begin
      r_done  <= w_acc;
      r_rdMem <= w_acc && !w_we && (w_sel == 3'd0);
      r_regRd <= (w_acc && !w_we) ? w_rdVal : '0;
      if (w_cfgWr) begin
        case (w_sel)
          3'd1:    r_busStart  <= valueB;
          3'd2:    r_memStart  <= valueB[AW-1:0];
          3'd3:    r_lineLen   <= valueB[15:0];
          3'd4:    r_burst     <= (valueB > {24'd0, BURST_MAX}) ? BURST_MAX : valueB[7:0];
          3'd5:    r_lineCount <= valueB[15:0];
          3'd6:    r_stride    <= valueB;
          3'd7:    r_err       <= 1'b0;
          default: ;
        endcase
      end
      case (r_state)
        S_IDLE: begin
          if (r_busy) r_busy <= 1'b0;
          else if (w_go) begin
            r_busy  <= 1'b1;
            r_dirWr <= valueB[1];
            if ((r_lineLen != 16'd0) && (r_lineCount != 16'd0)) begin
              r_lineBase  <= r_busStart;
              r_memPtr    <= r_memStart;
              r_wordsLeft <= r_lineLen;
              r_linesLeft <= r_lineCount;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: if (dmaAckBusIn) r_state <= S_BEGIN;
        S_BEGIN: begin
          r_burstLeft <= w_burstWords;
          r_state     <= w_err ? S_ERROR : (r_dirWr ? S_WR_DATA : S_RD_DATA);
        end
        S_RD_DATA: begin
          if (w_err) r_state <= S_ERROR;
          else begin
            if (dmaDataValidIn) begin
              r_memPtr    <= r_memPtr + PTR_ONE;
              r_wordsLeft <= r_wordsLeft - 16'd1;
            end
            if (dmaEndTransactionIn) r_state <= S_NEXT;
          end
        end
        S_WR_DATA: begin
          if (w_err) r_state <= S_ERROR;
          else if (!dmaBusyIn) begin
            r_memPtr    <= r_memPtr + PTR_ONE;
            r_wordsLeft <= r_wordsLeft - 16'd1;
            r_burstLeft <= r_burstLeft - 16'd1;
            if (r_burstLeft == 16'd1) r_state <= S_WR_END;
          end
        end
        S_WR_END: r_state <= w_err ? S_ERROR : S_NEXT;
        S_NEXT: begin
          if (r_wordsLeft != 16'd0) r_state <= S_REQ;
          else if (r_linesLeft == 16'd1) begin
            r_linesLeft <= 16'd0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_linesLeft <= r_linesLeft - 16'd1;
            r_lineBase  <= r_lineBase + r_stride;
            r_wordsLeft <= r_lineLen;
            r_state     <= S_REQ;
          end
        end
        default: begin
          r_err       <= 1'b1;
          r_busy      <= 1'b0;
          r_linesLeft <= 16'd0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign done   = r_done;
  assign result = r_rdMem ? r_cpuRd : r_regRd;

  // Bus outputs are gated by reset so the request drops in the reset cycle itself.
  always_comb begin
    dmaRequestBusOut       = 1'b0;
    dmaBeginTransactionOut = 1'b0;
    dmaAddressDataOut      = '0;
    dmaBurstSizeOut        = '0;
    dmaByteEnablesOut      = '0;
    dmaDataValidOut        = 1'b0;
    dmaEndTransactionOut   = 1'b0;
    if (!reset) begin
      case (r_state)
        S_REQ: dmaRequestBusOut = 1'b1;
        S_BEGIN: begin
          dmaRequestBusOut       = 1'b1;
          dmaBeginTransactionOut = 1'b1;
          dmaAddressDataOut      = r_lineBase + {14'd0, w_off, 2'b00};
          dmaBurstSizeOut        = w_burstM1[7:0];
        end
        S_RD_DATA: begin
          dmaRequestBusOut  = 1'b1;
          dmaByteEnablesOut = 4'hF;
        end
        S_WR_DATA: begin
          dmaRequestBusOut  = 1'b1;
          dmaByteEnablesOut = 4'hF;
          dmaDataValidOut   = 1'b1;
          dmaAddressDataOut = r_engRd;
        end
        S_WR_END: begin
          dmaRequestBusOut     = 1'b1;
          dmaEndTransactionOut = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
